// File: rtl/fusion_feedback_distributor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fusion_pkg
// Purpose  : Shared constants and FSM encoding for the fusion feedback path.
// Revision : 1.0
// ============================================================================
package fusion_pkg;

    localparam int N_STATES = 6;
    localparam int XW       = 16;
    localparam int PFW      = 32;
    localparam int PW       = 16;
    localparam int GW       = 16;
    localparam int GFRAC    = 12;
    localparam int PRODW    = 48;
    localparam int IDXW     = 4;

    localparam logic [GW-1:0]   GAMMA_ONE = 16'd4096;
    localparam logic [IDXW-1:0] LAST_IDX  = 4'd11;
    localparam logic [IDXW-1:0] SENSOR2_IDX = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fusion_feedback_distributor_if.sv
`default_nettype none
// ============================================================================
// Module   : fusion_feedback_distributor_if
// Purpose  : Fused-estimate input channel plus the two per-sensor outputs.
// Revision : 1.0
// ============================================================================
interface fusion_feedback_distributor_if;
    import fusion_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [N_STATES*XW-1:0]  xf_in;
    logic [N_STATES*PFW-1:0] pf_in;
    logic [GW-1:0]           gamma1;
    logic [GW-1:0]           gamma2;

    logic                    out1_valid;
    logic                    out1_ready;
    logic [N_STATES*XW-1:0]  x1_out;
    logic [N_STATES*PW-1:0]  p1_out;

    logic                    out2_valid;
    logic                    out2_ready;
    logic [N_STATES*XW-1:0]  x2_out;
    logic [N_STATES*PW-1:0]  p2_out;

    modport master (
        output in_valid, xf_in, pf_in, gamma1, gamma2, out1_ready, out2_ready,
        input  in_ready, out1_valid, x1_out, p1_out, out2_valid, x2_out, p2_out
    );

    modport slave (
        input  in_valid, xf_in, pf_in, gamma1, gamma2, out1_ready, out2_ready,
        output in_ready, out1_valid, x1_out, p1_out, out2_valid, x2_out, p2_out
    );

endinterface
`default_nettype wire

// File: rtl/fusion_feedback_distributor_cov_scale.sv
`default_nettype none
// ============================================================================
// Module   : cov_scale_unit
// Purpose  : Pf * gamma (Q4.12) with floor shift; FEEDBACK_SAT_EN selects
//            clamp-to-[0,32767] instead of plain truncation to PW bits.
// Revision : 1.0
// ============================================================================
module cov_scale_unit
    import fusion_pkg::*;
(
    input  wire logic [PFW-1:0] pf_i,
    input  wire logic [GW-1:0]  gamma_i,
    output logic      [PW-1:0]  p_o
);

    logic [PRODW-1:0] w_a;
    logic [PRODW-1:0] w_b;

    // Gamma is unsigned, so it is zero-extended before the signed multiply.
    assign w_a = {{(PRODW-PFW){pf_i[PFW-1]}}, pf_i};
    assign w_b = {{(PRODW-GW){1'b0}}, gamma_i};

`ifdef FEEDBACK_SAT_EN
    logic signed [PRODW-1:0] w_res;

    assign w_res = ($signed(w_a) * $signed(w_b)) >>> GFRAC;

    always_comb begin
        p_o = w_res[PW-1:0];
        if (w_res[PRODW-1]) begin
            p_o = '0;
        end else if (w_res > 48'sd32767) begin
            p_o = 16'h7FFF;
        end
    end
`else
    assign p_o = PW'(($signed(w_a) * $signed(w_b)) >>> GFRAC);
`endif

endmodule
`default_nettype wire

// File: rtl/fusion_feedback_distributor.sv
`default_nettype none
// ============================================================================
// Module   : fusion_feedback_distributor
// Purpose  : Redistributes one fused estimate to two local filters through a
//            single time-shared scaler. Optional macro: FEEDBACK_SAT_EN.
// Revision : 1.0
// ============================================================================
module fusion_feedback_distributor
    import fusion_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    fusion_feedback_distributor_if.slave bus
);

    state_e                  state_q;
    state_e                  state_d;
    logic                    w_in_ready;

    logic [IDXW-1:0]         idx_q;
    logic [N_STATES*XW-1:0]  xf_q;
    logic [N_STATES*PFW-1:0] pf_q;
    logic [GW-1:0]           g1_q;
    logic [GW-1:0]           g2_q;

    logic [N_STATES*XW-1:0]  x1_q;
    logic [N_STATES*XW-1:0]  x2_q;
    logic [N_STATES*PW-1:0]  p1_q;
    logic [N_STATES*PW-1:0]  p2_q;
    logic                    v1_q;
    logic                    v2_q;

    logic                    w_sec;
    logic [2:0]              w_s;
    logic [PFW-1:0]          w_pf;
    logic [GW-1:0]           w_gamma;
    logic [PW-1:0]           w_p;
    logic                    w_hs1;
    logic                    w_hs2;

    // Products 0-5 serve sensor 1, products 6-11 serve sensor 2.
    assign w_sec   = (idx_q >= SENSOR2_IDX);
    assign w_s     = w_sec ? 3'(idx_q - SENSOR2_IDX) : 3'(idx_q);
    assign w_pf    = pf_q[w_s*PFW +: PFW];
    assign w_gamma = w_sec ? g2_q : g1_q;

    assign w_hs1 = v1_q & bus.out1_ready;
    assign w_hs2 = v2_q & bus.out2_ready;

    cov_scale_unit u_scale (
        .pf_i    (w_pf),
        .gamma_i (w_gamma),
        .p_o     (w_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (idx_q == LAST_IDX) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Leave only once every still-pending channel completes now.
                if ((!v1_q || bus.out1_ready) && (!v2_q || bus.out2_ready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            xf_q  <= '0;
            pf_q  <= '0;
            g1_q  <= '0;
            g2_q  <= '0;
            x1_q  <= '0;
            x2_q  <= '0;
            p1_q  <= '0;
            p2_q  <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        xf_q  <= bus.xf_in;
                        pf_q  <= bus.pf_in;
                        g1_q  <= bus.gamma1;
                        g2_q  <= bus.gamma2;
                        idx_q <= '0;
                    end
                end
                CALC: begin
                    if (w_sec) begin
                        p2_q[w_s*PW +: PW] <= w_p;
                    end else begin
                        p1_q[w_s*PW +: PW] <= w_p;
                    end
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        x1_q <= xf_q;
                        x2_q <= xf_q;
                        v1_q <= 1'b1;
                        v2_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_hs1) begin
                        v1_q <= 1'b0;
                    end
                    if (w_hs2) begin
                        v2_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out1_valid = v1_q;
    assign bus.out2_valid = v2_q;
    assign bus.x1_out     = x1_q;
    assign bus.x2_out     = x2_q;
    assign bus.p1_out     = p1_q;
    assign bus.p2_out     = p2_q;

endmodule
`default_nettype wire

// File: tb/tb_fusion_feedback_distributor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fusion_feedback_distributor
// Purpose  : Scoreboard bench for the fusion feedback distributor.
// Revision : 1.0
// ============================================================================
module tb_fusion_feedback_distributor;
    import fusion_pkg::*;

`ifdef FEEDBACK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [95:0] x;
        logic [95:0] p;
        int          edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fusion_feedback_distributor_if bus ();

    fusion_feedback_distributor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q1[$];
    exp_t q2[$];
    exp_t cur1;
    exp_t cur2;
    bit   seen1 = 1'b0;
    bit   seen2 = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Channel monitors: pop on the first valid cycle, then check stability.
    always @(negedge clk) begin
        if (rst_n && bus.out1_valid) begin
            if (!seen1) begin
                if (q1.size() == 0) begin
                    chk("ch1_unexpected_valid", 96'd1, 96'd0);
                end else begin
                    cur1 = q1.pop_front();
                    seen1 = 1'b1;
                    chk("ch1_latency", 96'(cyc), 96'(cur1.edge_n + 12));
                    chk("ch1_x", bus.x1_out, cur1.x);
                    chk("ch1_p", bus.p1_out, cur1.p);
                end
            end else begin
                chk("ch1_hold_x", bus.x1_out, cur1.x);
                chk("ch1_hold_p", bus.p1_out, cur1.p);
            end
            if (bus.out1_ready) seen1 = 1'b0;
        end else begin
            seen1 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out2_valid) begin
            if (!seen2) begin
                if (q2.size() == 0) begin
                    chk("ch2_unexpected_valid", 96'd1, 96'd0);
                end else begin
                    cur2 = q2.pop_front();
                    seen2 = 1'b1;
                    chk("ch2_latency", 96'(cyc), 96'(cur2.edge_n + 12));
                    chk("ch2_x", bus.x2_out, cur2.x);
                    chk("ch2_p", bus.p2_out, cur2.p);
                end
            end else begin
                chk("ch2_hold_x", bus.x2_out, cur2.x);
                chk("ch2_hold_p", bus.p2_out, cur2.p);
            end
            if (bus.out2_ready) seen2 = 1'b0;
        end else begin
            seen2 = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [5:0][15:0] x, input logic [5:0][31:0] pf,
                        input logic [15:0] g1, input logic [15:0] g2,
                        input logic [5:0][15:0] e1, input logic [5:0][15:0] e2,
                        input bit keep_valid, output int acc);
        exp_t e;
        int   t;
        bus.xf_in    = x;
        bus.pf_in    = pf;
        bus.gamma1   = g1;
        bus.gamma2   = g2;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 96'd0, 96'd1);
            acc = -1;
        end else begin
            acc = cyc + 1;
            e.x = x;
            e.edge_n = acc;
            e.p = e1;
            q1.push_back(e);
            e.p = e2;
            q2.push_back(e);
        end
        @(negedge clk);
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q1.size() != 0 || q2.size() != 0 || bus.out1_valid || bus.out2_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 96'(t >= 300), 96'd0);
        @(negedge clk);
    endtask

    logic [5:0][15:0] xa, xb, xc, e1a, e2a, e1b, e2b, e1c, e2c;
    logic [5:0][31:0] pfa, pfb, pfc;
    int               acc_a, acc_b, t;

    initial begin
        // Job A: Pf=100, gamma1=4.0, gamma2~1.333
        for (int k = 0; k < 6; k++) begin
            xa[k]  = 16'(100 + 10 * k);
            pfa[k] = 32'd100;
            e1a[k] = 16'd400;
            e2a[k] = 16'd133;
        end
        // Job B: saturation on Pf[0], gamma2=0
        for (int k = 0; k < 6; k++) begin
            xb[k]  = 16'(16'hA000 + k);
            pfb[k] = 32'd1000;
            e1b[k] = 16'd4000;
            e2b[k] = 16'd0;
        end
        pfb[0] = 32'd20000;
        e1b[0] = SAT ? 16'd32767 : 16'd14464;
        // Job C: negative values, gamma1=1.0, gamma2=0.5 (floor on -3.5)
        for (int k = 0; k < 6; k++) begin
            xc[k]  = 16'(16'hFFF0 - k);
            pfc[k] = 32'd300;
            e1c[k] = 16'd300;
            e2c[k] = 16'd150;
        end
        pfc[1] = 32'hFFFF_FFCE;
        pfc[2] = 32'hFFFF_FFF9;
        e1c[1] = SAT ? 16'h0000 : 16'hFFCE;
        e1c[2] = SAT ? 16'h0000 : 16'hFFF9;
        e2c[1] = SAT ? 16'h0000 : 16'hFFE7;
        e2c[2] = SAT ? 16'h0000 : 16'hFFFC;

        bus.in_valid   = 1'b0;
        bus.xf_in      = '0;
        bus.pf_in      = '0;
        bus.gamma1     = '0;
        bus.gamma2     = '0;
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out1_valid", 96'(bus.out1_valid), 96'd0);
        chk("rst_out2_valid", 96'(bus.out2_valid), 96'd0);
        chk("rst_p1_out", bus.p1_out, 96'd0);
        chk("rst_x2_out", bus.x2_out, 96'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 96'(bus.in_ready), 96'd1);

        send(xa, pfa, 16'd16384, 16'd5461, e1a, e2a, 1'b0, acc_a);
        drain();
        send(xb, pfb, 16'd16384, 16'd0, e1b, e2b, 1'b0, acc_a);
        drain();
        send(xc, pfc, GAMMA_ONE, 16'd2048, e1c, e2c, 1'b0, acc_a);
        drain();

        // Independent handshake: channel 2 held off
        bus.out2_ready = 1'b0;
        send(xa, pfa, 16'd16384, 16'd5461, e1a, e2a, 1'b0, acc_a);
        t = 0;
        while (!bus.out1_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out1_valid", 96'(bus.out1_valid), 96'd0);
            chk("hold_out2_valid", 96'(bus.out2_valid), 96'd1);
            chk("hold_in_ready", 96'(bus.in_ready), 96'd0);
        end
        bus.out2_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 96'(bus.in_ready), 96'd1);
        chk("release_out2_valid", 96'(bus.out2_valid), 96'd0);
        drain();

        // Back-to-back: in_valid held across two jobs
        send(xb, pfb, 16'd16384, 16'd0, e1b, e2b, 1'b1, acc_a);
        send(xc, pfc, GAMMA_ONE, 16'd2048, e1c, e2c, 1'b0, acc_b);
        chk("b2b_accept_gap", 96'(acc_b - acc_a), 96'd14);
        drain();

        // Reset while index 5 is loaded
        send(xa, pfa, 16'd16384, 16'd5461, e1a, e2a, 1'b0, acc_a);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out1_valid", 96'(bus.out1_valid), 96'd0);
        chk("midrst_out2_valid", 96'(bus.out2_valid), 96'd0);
        chk("midrst_p1_out", bus.p1_out, 96'd0);
        chk("midrst_p2_out", bus.p2_out, 96'd0);
        chk("midrst_x1_out", bus.x1_out, 96'd0);
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 96'(bus.in_ready), 96'd1);
        chk("postrst_no_valid", 96'(bus.out1_valid | bus.out2_valid), 96'd0);
        send(xc, pfc, GAMMA_ONE, 16'd2048, e1c, e2c, 1'b0, acc_a);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
